// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin arbiter between two requesters sharing one
// memory port, plus a sequenced clear engine that zeroes every word with one
// write per cycle.
module mem_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,

    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,

    output logic [DATA_W-1:0] rdata,

    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              last_b_q, last_b_d;     // 1: B was granted most recently
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic              clr_done_q, clr_done_d;
    logic              grant_a, grant_b;

    // Next-state, grant and memory-port selection
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        last_b_d   = last_b_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        clr_done_d = 1'b0;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    // clear wins over any simultaneous request
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    grant_a = a_valid && (!b_valid || last_b_q);
                    grant_b = b_valid && !grant_a;
                end

                if (grant_a) begin
                    mem_we     = a_we;
                    mem_addr   = a_addr;
                    mem_wdata  = a_wdata;
                    last_b_d   = 1'b0;
                    a_rvalid_d = !a_we;
                end else if (grant_b) begin
                    mem_we     = b_we;
                    mem_addr   = b_addr;
                    mem_wdata  = b_wdata;
                    last_b_d   = 1'b1;
                    b_rvalid_d = !b_we;
                end
            end

            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d    = IDLE;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign rdata    = mem_rdata;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a behavioural memory, a spec-level reference
// model checked every cycle, a vector table, hand sequences and random traffic.
module tb_mem_access_ctrl;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        a_valid, a_we, b_valid, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [15:0] rdata;
    logic        clr_req, clr_busy, clr_done;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        tb_mem_zero;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16x16 memory with registered read
    logic [15:0] mem [DEPTH];
    always @(posedge clk) begin
        if (tb_mem_zero) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0;
            mem_rdata <= 16'h0;
        end else begin
            if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference model state, expressed as counts and remembered transactions
    logic [15:0] model_mem [DEPTH];
    int          m_clr_left;     // clear write cycles still to run
    int          m_clr_idx;      // next word the clear engine writes
    bit          m_done;
    bit          m_last_a;       // A won the most recent grant
    bit          m_rv_a, m_rv_b;
    logic [15:0] m_rv_data;

    // Values sampled from the DUT in the most recent step
    logic        s_ar, s_br, s_arv, s_brv, s_we, s_busy, s_done;
    logic [3:0]  s_addr;
    logic [15:0] s_rdata;
    bit          last_ga, last_gb;

    task automatic model_reset();
        m_clr_left = 0;
        m_clr_idx  = 0;
        m_done     = 0;
        m_last_a   = 0;
        m_rv_a     = 0;
        m_rv_b     = 0;
        m_rv_data  = 16'h0;
    endtask

    // One clock cycle: sample and check at negedge, advance the model, then
    // return just after the following posedge so inputs can be changed.
    task automatic step();
        bit busy, ga, gb, nrv_a, nrv_b;
        logic [15:0] nrv_data;
        @(negedge clk);
        s_ar = a_ready;  s_br = b_ready;  s_arv = a_rvalid; s_brv = b_rvalid;
        s_we = mem_we;   s_busy = clr_busy; s_done = clr_done;
        s_addr = mem_addr; s_rdata = rdata;

        busy = (m_clr_left != 0);
        ga = 0; gb = 0;
        if (!busy && !clr_req) begin
            if (a_valid && b_valid) begin
                ga = !m_last_a;
                gb = m_last_a;
            end else begin
                ga = a_valid;
                gb = b_valid;
            end
        end

        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("clr_busy", clr_busy, busy);
        chk("clr_done", clr_done, m_done);
        chk("a_rvalid", a_rvalid, m_rv_a);
        chk("b_rvalid", b_rvalid, m_rv_b);
        if (m_rv_a || m_rv_b) chk("rdata", rdata, m_rv_data);
        if (busy) begin
            chk("clear_we", mem_we, 1);
            chk("clear_addr", mem_addr, m_clr_idx);
            chk("clear_wdata", mem_wdata, 0);
        end else if (ga) begin
            chk("a_mem_we", mem_we, a_we);
            chk("a_mem_addr", mem_addr, a_addr);
            if (a_we) chk("a_mem_wdata", mem_wdata, a_wdata);
        end else if (gb) begin
            chk("b_mem_we", mem_we, b_we);
            chk("b_mem_addr", mem_addr, b_addr);
            if (b_we) chk("b_mem_wdata", mem_wdata, b_wdata);
        end else begin
            chk("idle_mem_we", mem_we, 0);
            if (!a_valid && !b_valid) chk("idle_mem_addr", mem_addr, 0);
        end

        nrv_a = ga && !a_we;
        nrv_b = gb && !b_we;
        nrv_data = m_rv_data;
        if (nrv_a) nrv_data = model_mem[a_addr];
        if (nrv_b) nrv_data = model_mem[b_addr];
        if (ga && a_we) model_mem[a_addr] = a_wdata;
        if (gb && b_we) model_mem[b_addr] = b_wdata;

        m_done = 0;
        if (busy) begin
            model_mem[m_clr_idx] = 16'h0;
            m_clr_idx++;
            m_clr_left--;
            if (m_clr_left == 0) begin
                m_done    = 1;
                m_clr_idx = 0;
            end
        end else if (clr_req) begin
            m_clr_left = DEPTH;
            m_clr_idx  = 0;
        end
        if (ga) m_last_a = 1;
        if (gb) m_last_a = 0;
        m_rv_a = nrv_a;
        m_rv_b = nrv_b;
        m_rv_data = nrv_data;
        if (!rst_n) model_reset();
        last_ga = ga;
        last_gb = gb;

        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        clr;
        logic        av, awe;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        bv, bwe;
        logic [3:0]  ba;
        logic [15:0] bd;
        logic        e_ar, e_br, e_arv, e_brv, e_we;
        logic [3:0]  e_addr;
        logic [15:0] e_rdata;
        logic        e_busy, e_done;
    } vec_t;

    vec_t vecs [8];

    int  busy_cnt, zero_cnt;
    bit  seen_done, addr_ok, early;

    initial begin
        // Reset-state check, 4-cycle A/B alternation, then write/read-back of addr 3
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 4'd1, 16'h0,    1'b1, 1'b0, 4'd2, 16'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0,    1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd1, 16'h0,    1'b1, 1'b0, 4'd2, 16'h0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0,    1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 4'd1, 16'h0,    1'b1, 1'b0, 4'd2, 16'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0,    1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'd1, 16'h0,    1'b1, 1'b0, 4'd2, 16'h0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0,    1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 4'd0, 16'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0,    1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 4'd3, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0,    1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'hBEEF, 1'b0, 1'b0};

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0;
        model_reset();
        rst_n = 1'b0; tb_mem_zero = 1'b1; clr_req = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wdata = 16'h0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        tb_mem_zero = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            clr_req = vecs[i].clr;
            a_valid = vecs[i].av; a_we = vecs[i].awe; a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
            b_valid = vecs[i].bv; b_we = vecs[i].bwe; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
            step();
            chk($sformatf("vec%0d_a_ready", i), s_ar, vecs[i].e_ar);
            chk($sformatf("vec%0d_b_ready", i), s_br, vecs[i].e_br);
            chk($sformatf("vec%0d_a_rvalid", i), s_arv, vecs[i].e_arv);
            chk($sformatf("vec%0d_b_rvalid", i), s_brv, vecs[i].e_brv);
            chk($sformatf("vec%0d_mem_we", i), s_we, vecs[i].e_we);
            chk($sformatf("vec%0d_mem_addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_clr_busy", i), s_busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_clr_done", i), s_done, vecs[i].e_done);
            if (vecs[i].e_arv || vecs[i].e_brv)
                chk($sformatf("vec%0d_rdata", i), s_rdata, vecs[i].e_rdata);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Fill with 0xFFFF, clear, confirm 16 busy cycles on addresses 0..15, read back zeros
        a_valid = 1'b1; a_we = 1'b1; a_wdata = 16'hFFFF;
        for (int i = 0; i < DEPTH; i++) begin
            a_addr = 4'(i);
            step();
        end
        a_valid = 1'b0;
        clr_req = 1'b1;
        step();
        chk("clr_req_cycle_not_busy", s_busy, 0);
        clr_req = 1'b0;
        busy_cnt = 0; seen_done = 0; addr_ok = 1;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            step();
            if (s_busy) begin
                if (s_addr != 4'(busy_cnt)) addr_ok = 0;
                busy_cnt++;
            end
            if (s_done) seen_done = 1;
        end
        chk("clr_busy_cycles", busy_cnt, DEPTH);
        chk("clr_done_seen", seen_done, 1);
        chk("clr_addr_sequence", addr_ok, 1);
        a_valid = 1'b1; a_we = 1'b0;
        zero_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            a_addr = 4'(i);
            step();
            if (s_arv && s_rdata == 16'h0) zero_cnt++;
        end
        a_valid = 1'b0;
        step();
        if (s_arv && s_rdata == 16'h0) zero_cnt++;
        chk("clr_readback_zero", zero_cnt, DEPTH);

        // clr_req and a_valid together: A waits until the clr_done cycle
        a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd6; clr_req = 1'b1;
        step();
        chk("t4_no_grant_on_clr", s_ar, 0);
        clr_req = 1'b0;
        early = 0; seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            step();
            if (s_done) begin
                seen_done = 1;
                chk("t4_grant_in_done", s_ar, 1);
            end else if (s_ar) begin
                early = 1;
            end
        end
        chk("t4_done_seen", seen_done, 1);
        chk("t4_no_early_grant", early, 0);
        a_valid = 1'b0;
        step();

        // Reset during clear cycle 7 aborts without clr_done
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        step();
        chk("t5_cycle7_addr", s_addr, 7);
        rst_n = 1'b1;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd9;
        step();
        chk("t5_busy_after_reset", s_busy, 0);
        chk("t5_no_done", s_done, 0);
        chk("t5_read_granted", s_ar, 1);
        a_valid = 1'b0;
        step();
        chk("t5_rvalid", s_arv, 1);

        // B read accepted just before a clear still returns pre-clear data
        a_valid = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 16'h1234;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd5;
        step();
        chk("t6_b_ready", s_br, 1);
        b_valid = 1'b0;
        clr_req = 1'b1;
        step();
        chk("t6_b_rvalid", s_brv, 1);
        chk("t6_b_rdata", s_rdata, 16'h1234);
        clr_req = 1'b0;
        step();
        chk("t6_clear_started", s_busy, 1);
        chk("t6_clear_addr0", s_addr, 0);
        seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            step();
            if (s_done) seen_done = 1;
        end
        chk("t6_done_seen", seen_done, 1);

        // Random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            clr_req = ($urandom_range(0, 39) == 0);
            if (!rst_n) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end else begin
                if (!a_valid && $urandom_range(0, 1) == 1) begin
                    a_valid = 1'b1;
                    a_we    = 1'($urandom_range(0, 1));
                    a_addr  = 4'($urandom);
                    a_wdata = 16'($urandom);
                end
                if (!b_valid && $urandom_range(0, 1) == 1) begin
                    b_valid = 1'b1;
                    b_we    = 1'($urandom_range(0, 1));
                    b_addr  = 4'($urandom);
                    b_wdata = 16'($urandom);
                end
            end
            step();
            if (last_ga) a_valid = 1'b0;
            if (last_gb) b_valid = 1'b0;
        end
        rst_n = 1'b1; clr_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
